// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the collision classifier / game logic and snake_game_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface snake_game_ctrl_if #(
    parameter int LEN_W = 5
);
    logic [1:0]       collision_state_i;
    logic             frame_end_i;
    logic             start_i;
    logic             move_tick_o;
    logic             grow_o;
    logic             apple_respawn_o;
    logic             running_o;
    logic             game_over_o;
    logic [LEN_W-1:0] snake_len_o;
    logic [7:0]       score_o;

    modport slave (
        input  collision_state_i, frame_end_i, start_i,
        output move_tick_o, grow_o, apple_respawn_o, running_o, game_over_o,
               snake_len_o, score_o
    );

    modport master (
        output collision_state_i, frame_end_i, start_i,
        input  move_tick_o, grow_o, apple_respawn_o, running_o, game_over_o,
               snake_len_o, score_o
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Frame-level snake game controller: folds per-pixel collision codes into per-frame
// hit/apple decisions and drives the game FSM, move tick, length and BCD score.
module snake_game_ctrl #(
    parameter int START_LEN       = 3,
    parameter int MAX_LEN         = 16,
    parameter int LEN_W           = 5,
    parameter int FRAMES_PER_MOVE = 8,
    parameter int FCNT_W          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    snake_game_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // BCD increment that saturates at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        score_q, score_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              hit_q, hit_d;
    logic              apple_q, apple_d;
    logic              move_q, move_d;
    logic              grow_q, grow_d;
    logic              resp_q, resp_d;
    logic              running_q, running_d;
    logic              over_q, over_d;
    logic              hit_now_s, apple_now_s, hit_eff_s, apple_eff_s;

    // Next-state, counters and pulse generation
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        score_d     = score_q;
        fcnt_d      = fcnt_q;
        hit_d       = hit_q;
        apple_d     = apple_q;
        move_d      = 1'b0;
        grow_d      = 1'b0;
        resp_d      = 1'b0;
        hit_now_s   = (bus.collision_state_i == 2'b01);
        apple_now_s = (bus.collision_state_i == 2'b10);
        hit_eff_s   = hit_q | hit_now_s;
        apple_eff_s = apple_q | apple_now_s;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                    resp_d  = 1'b1;
                    len_d   = LEN_W'(START_LEN);
                    score_d = 8'h00;
                    fcnt_d  = '0;
                    hit_d   = 1'b0;
                    apple_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.frame_end_i) begin
                    // The frame_end cycle's own code belongs to the frame that is ending
                    hit_d   = 1'b0;
                    apple_d = 1'b0;
                    if (hit_eff_s) begin
                        state_d = ST_OVER;
                    end else begin
                        if (apple_eff_s) begin
                            grow_d  = 1'b1;
                            resp_d  = 1'b1;
                            score_d = bcd_inc(score_q);
                            if (len_q < LEN_W'(MAX_LEN)) begin
                                len_d = len_q + LEN_W'(1);
                            end else begin
                                len_d = len_q;
                            end
                        end else begin
                            grow_d = 1'b0;
                        end
                        if (fcnt_q == FCNT_W'(FRAMES_PER_MOVE - 1)) begin
                            move_d = 1'b1;
                            fcnt_d = '0;
                        end else begin
                            fcnt_d = fcnt_q + FCNT_W'(1);
                        end
                    end
                end else begin
                    hit_d   = hit_eff_s;
                    apple_d = apple_eff_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hit_d   = 1'b0;
                apple_d = 1'b0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        over_d    = (state_d == ST_OVER);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= LEN_W'(START_LEN);
            score_q   <= 8'h00;
            fcnt_q    <= '0;
            hit_q     <= 1'b0;
            apple_q   <= 1'b0;
            move_q    <= 1'b0;
            grow_q    <= 1'b0;
            resp_q    <= 1'b0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            score_q   <= score_d;
            fcnt_q    <= fcnt_d;
            hit_q     <= hit_d;
            apple_q   <= apple_d;
            move_q    <= move_d;
            grow_q    <= grow_d;
            resp_q    <= resp_d;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    assign bus.move_tick_o     = move_q;
    assign bus.grow_o          = grow_q;
    assign bus.apple_respawn_o = resp_q;
    assign bus.running_o       = running_q;
    assign bus.game_over_o     = over_q;
    assign bus.snake_len_o     = len_q;
    assign bus.score_o         = score_q;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game-level controller downstream of the per-pixel collision classifier. It accumulates the 2-bit collision code over each video frame and resolves the result once per frame at frame_end_i. It runs the IDLE/RUN/GAME_OVER state machine, generates the snake move tick, and maintains snake length and a 2-digit BCD score. Its outputs feed the snake body/position logic, the apple generator and the score display.

Parameters:
START_LEN, 3, snake length loaded at reset and at every game start
MAX_LEN, 16, length saturation value; must be less than 2^LEN_W
LEN_W, 5, width of snake_len_o
FRAMES_PER_MOVE, 8, frames per move tick; must be at least 1
FCNT_W, 4, frame counter width; must satisfy 2^FCNT_W >= FRAMES_PER_MOVE

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous, active-low reset
collision_state_i  in  2  per-pixel collision code: 00 reset, 01 collision, 10 apple collected, 11 no collision
frame_end_i  in  1  one-cycle pulse at the last pixel of each frame
start_i  in  1  start request, level or pulse; sampled every cycle
move_tick_o  out  1  one-cycle pulse: snake advances one cell
grow_o  out  1  one-cycle pulse: append one body segment
apple_respawn_o  out  1  one-cycle pulse: place a new apple
running_o  out  1  high while in RUN
game_over_o  out  1  high while in GAME_OVER
snake_len_o  out  LEN_W  current snake length
score_o  out  8  BCD score: [7:4] tens digit, [3:0] ones digit

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, snake_len_o=START_LEN, score_o=8'h00, frame counter=0, hit_f=0, apple_f=0. All pulse outputs, running_o and game_over_o are 0.
- All outputs are registered. Every pulse appears in the cycle after the triggering input edge and lasts exactly 1 cycle.
- IDLE:
  - On start_i=1: go to RUN; pulse apple_respawn_o; reload snake_len_o=START_LEN; clear score, frame counter and both flags.
- RUN (running_o=1):
  - Sticky flags: hit_f is set when collision_state_i==01; apple_f is set when collision_state_i==10. Codes 00 and 11 have no effect.
  - At frame_end_i, the effective flags are the sticky flags OR the code sampled in that same cycle.
  - At frame_end_i, priority order:
    - effective hit: go to GAME_OVER. No grow, no score change, no move tick.
    - else effective apple: pulse grow_o and apple_respawn_o. snake_len_o += 1, saturating at MAX_LEN; grow_o still pulses at saturation. Score increments in BCD: ones 9 wraps to 0 and carries into tens; 99 saturates at 99.
    - Frame counter (only when no hit): if counter == FRAMES_PER_MOVE-1, pulse move_tick_o and set counter to 0; else counter += 1. grow_o and move_tick_o may pulse in the same cycle.
  - Both sticky flags clear at every frame_end_i. A code arriving in the frame_end_i cycle counts toward the ending frame, not the next one.
  - start_i is ignored in RUN.
- GAME_OVER (game_over_o=1):
  - snake_len_o and score_o hold their values. No pulses are generated. Collision codes are ignored.
  - On start_i=1: go to RUN with the same reinitialisation as the IDLE start, including the apple_respawn_o pulse.
- A start_i held high does not retrigger while the block stays in RUN.
- rst_n asserted in any state, mid-frame or mid-pulse: immediate return to reset values. No pulse survives the reset.
- FRAMES_PER_MOVE=1: move_tick_o pulses at every non-hit frame_end_i.

Test Plan:
- Reset then start_i pulse -> running_o=1, exactly one apple_respawn_o pulse, snake_len_o=3, score_o=00; 8 clean frames (code 11 only) -> exactly one move_tick_o, after the 8th frame_end_i.
- One pixel with code 10 mid-frame, then frame_end_i -> grow_o and apple_respawn_o pulse once, snake_len_o=4, score_o=01. The following clean frame produces no grow_o.
- Codes 10 and 01 both appear in one frame -> GAME_OVER at frame_end_i, score_o and snake_len_o unchanged, no grow_o and no move_tick_o; later start_i -> RUN with len=3, score=00.
- Code 01 presented only in the same cycle as frame_end_i -> GAME_OVER. Code 01 one cycle after frame_end_i -> no effect until the next frame_end_i.
- 15 apple frames, then 90 more -> snake_len_o saturates at 16 while grow_o keeps pulsing; score runs 09->10, later reaches 99 and holds at 99.
- rst_n dropped mid-frame with hit_f set and move counter at 7 -> all outputs at reset values immediately; after release and start_i, a clean frame produces no game over and the first move tick occurs after 8 frames.
